// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB memory slave: transfer FSM state encoding
// and the width of the wait-state counter.
// ---------------------------------------------------------------------------
package apb_pkg;

    // Transfer FSM states. SETUP is the cycle in which the bus shows its
    // setup phase (psel=1, penable=0); WAIT holds off pready; ACCESS is the
    // single cycle that drives pready=1.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_e;

    // Wide enough for 0..15 wait states.
    localparam int WCNT_W = 4;

endpackage

// File: rtl/apb_sp_ram.sv
// ---------------------------------------------------------------------------
// apb_sp_ram
// Single-port word-organised storage with per-byte write enables.
// Read is combinational from addr; write commits on the rising clk edge,
// touching only the byte lanes whose wstrb bit is set. Contents are never
// reset.
//
// Ports:
//   clk   - clock
//   we    - write enable for this cycle
//   addr  - word index (shared by read and write)
//   wdata - write data
//   wstrb - byte-lane write strobes
//   rdata - word currently addressed
// ---------------------------------------------------------------------------
module apb_sp_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Byte-lane masked write; storage deliberately has no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
// APB slave in front of a DEPTH x DATA_W memory with byte strobes,
// WAIT_CYC programmable wait states and an error response for word indices
// beyond DEPTH. pready/pslverr/prdata are registered; with WAIT_CYC=0 the
// response appears in the first access-phase cycle.
//
// Ports:
//   pclk, prstn        - clock, asynchronous active-low reset
//   psel, penable      - APB select / access phase
//   pwrite             - 1 = write, 0 = read
//   paddr              - byte address (word index = upper bits)
//   pwdata, pstrb      - write data and byte-lane strobes
//   prdata             - read data, non-zero only in the read's pready cycle
//   pready, pslverr    - transfer complete / error (valid with pready)
// ---------------------------------------------------------------------------
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 32,
    parameter int WAIT_CYC = 0
) (
    input  logic                pclk,
    input  logic                prstn,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WCNT_W-1:0] CNT_LOAD  = WCNT_W'(WAIT_CYC);
    localparam logic [WCNT_W-1:0] CNT_ONE   = WCNT_W'(32'd1);
    localparam logic [WCNT_W-1:0] CNT_ZERO  = {WCNT_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [STRB_W-1:0] STRB_ZERO = {STRB_W{1'b0}};

    apb_state_e        state_r;
    apb_state_e        cur_state_s;
    logic [WCNT_W-1:0] cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic              pwrite_r;
    logic [DATA_W-1:0] wdata_r;
    logic [STRB_W-1:0] strb_r;
    logic [DATA_W-1:0] prdata_r;
    logic              pready_r;
    logic              pslverr_r;

    logic [IDX_W-1:0]  live_idx_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              sel_write_s;
    logic              oob_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic [DATA_W-1:0] acc_rdata_s;

    assign live_idx_s = paddr[ADDR_W-1:LSB];

    // Byte-offset bits select nothing inside a word.
    generate
        if (LSB > 0) begin : g_lsb_sink
            logic unused_lsb_s;
            assign unused_lsb_s = ^paddr[LSB-1:0];
        end
    endgenerate

    // Effective state of this cycle: an IDLE cycle carrying a setup phase is
    // the SETUP state, so the response can be registered in time for the
    // first access-phase cycle. psel=1 & penable=1 in IDLE stays IDLE.
    always_comb begin
        cur_state_s = state_r;
        if ((state_r == ST_IDLE) && psel && !penable) begin
            cur_state_s = ST_SETUP;
        end else begin
            cur_state_s = state_r;
        end
    end

    // Transfer being serviced: live bus fields during SETUP, captured copy after.
    always_comb begin
        sel_idx_s   = idx_r;
        sel_write_s = pwrite_r;
        if (cur_state_s == ST_SETUP) begin
            sel_idx_s   = live_idx_s;
            sel_write_s = pwrite;
        end else begin
            sel_idx_s   = idx_r;
            sel_write_s = pwrite_r;
        end
    end

    assign oob_s = (32'(sel_idx_s) >= 32'(DEPTH));

    // Commit only in the ACCESS cycle of an in-range write still selected.
    assign ram_we_s = (state_r == ST_ACCESS) && psel && pwrite_r && !oob_s;

    // Data to present in the ACCESS cycle: memory word for in-range reads only.
    always_comb begin
        acc_rdata_s = DATA_ZERO;
        if (!oob_s && !sel_write_s) begin
            acc_rdata_s = ram_rdata_s;
        end else begin
            acc_rdata_s = DATA_ZERO;
        end
    end

    // Transfer FSM with registered pready/pslverr/prdata.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            idx_r     <= IDX_ZERO;
            pwrite_r  <= 1'b0;
            wdata_r   <= DATA_ZERO;
            strb_r    <= STRB_ZERO;
            prdata_r  <= DATA_ZERO;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            case (cur_state_s)
                ST_SETUP: begin
                    idx_r    <= live_idx_s;
                    pwrite_r <= pwrite;
                    wdata_r  <= pwdata;
                    strb_r   <= pstrb;
                    cnt_r    <= CNT_LOAD;
                    if (WAIT_CYC > 0) begin
                        state_r   <= ST_WAIT;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                        prdata_r  <= DATA_ZERO;
                    end else begin
                        state_r   <= ST_ACCESS;
                        pready_r  <= 1'b1;
                        pslverr_r <= oob_s;
                        prdata_r  <= acc_rdata_s;
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        // Master abandoned the transfer: discard it.
                        state_r   <= ST_IDLE;
                        cnt_r     <= CNT_ZERO;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                        prdata_r  <= DATA_ZERO;
                    end else if (penable && (cnt_r <= CNT_ONE)) begin
                        state_r   <= ST_ACCESS;
                        cnt_r     <= CNT_ZERO;
                        pready_r  <= 1'b1;
                        pslverr_r <= oob_s;
                        prdata_r  <= acc_rdata_s;
                    end else if (penable) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_ACCESS: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    prdata_r  <= DATA_ZERO;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    prdata_r  <= DATA_ZERO;
                end
            endcase
        end
    end

    apb_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (pclk),
        .we    (ram_we_s),
        .addr  (sel_idx_s[RAM_AW-1:0]),
        .wdata (wdata_r),
        .wstrb (strb_r),
        .rdata (ram_rdata_s)
    );

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width in bits (multiple of 8, 8..64).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning byte-address width.
REQ-003 The block SHALL have parameter DEPTH, default 32, meaning number of DATA_W-bit words (<= 2**(ADDR_W-log2(DATA_W/8))).
REQ-004 The block SHALL have parameter WAIT_CYC, default 0, meaning wait states inserted per access (0..15).
REQ-005 The block SHALL have port pclk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 The block SHALL have port prstn, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port psel, input, 1, meaning slave select.
REQ-008 The block SHALL have port penable, input, 1, meaning access phase.
REQ-009 The block SHALL have port pwrite, input, 1, meaning 1 for write, 0 for read.
REQ-010 The block SHALL have port paddr, input, ADDR_W, meaning byte address; word index = paddr[ADDR_W-1:log2(DATA_W/8)].
REQ-011 The block SHALL have port pwdata, input, DATA_W, meaning write data.
REQ-012 The block SHALL have port pstrb, input, DATA_W/8, meaning byte-lane write strobes.
REQ-013 The block SHALL have port prdata, output, DATA_W, meaning read data.
REQ-014 The block SHALL have port pready, output, 1, meaning transfer complete.
REQ-015 The block SHALL have port pslverr, output, 1, meaning transfer error, valid only with pready=1.

Function
REQ-016 The block SHALL implement FSM states IDLE, SETUP, WAIT, ACCESS.
REQ-017 IDLE SHALL go to SETUP on psel=1 & penable=0; psel=1 & penable=1 in IDLE SHALL be ignored (pready=0, no write).
REQ-018 SETUP SHALL capture paddr, pwrite, pwdata, pstrb; load wait counter with WAIT_CYC; go to WAIT if WAIT_CYC>0, else ACCESS.
REQ-019 WAIT SHALL decrement the counter each cycle while psel & penable, going to ACCESS when it reaches 1; pready=0 throughout.
REQ-020 ACCESS SHALL assert pready=1 for exactly one cycle, then go to SETUP if psel=1 & penable=0, else IDLE.
REQ-021 Access latency SHALL be WAIT_CYC+1 cycles from first penable=1 cycle to pready=1 inclusive.
REQ-022 Writes SHALL commit on the ACCESS cycle edge, updating only byte lanes with pstrb[i]=1; pstrb=0 SHALL leave memory unchanged without error.
REQ-023 For reads, prdata SHALL equal the addressed word during the ACCESS cycle and 0 in all other cycles.
REQ-024 A word index >= DEPTH SHALL give pslverr=1 with pready, no memory write, prdata=0.
REQ-025 psel deasserting before ACCESS SHALL return the FSM to IDLE, discard the transfer, and perform no write.
REQ-026 A read immediately following a write to the same word SHALL return the newly written data.

Reset
REQ-027 prstn=0 SHALL asynchronously force state=IDLE, counter=0, prdata=0, pready=0, pslverr=0, including mid-transfer; no write SHALL occur that cycle.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset deassertion SHALL take effect on the first pclk edge after prstn rises.

Structure
REQ-030 State encoding and wait-counter width constant SHALL live in shared package apb_pkg.
REQ-031 The storage array with byte-lane write enables SHALL be sub-module apb_sp_ram (params DATA_W, DEPTH).

Verification
REQ-032 The bench SHALL cover this case: WAIT_CYC=0, write 0xA5A5_1234 to paddr 0x08 with pstrb=0xF, then read 0x08 -> pready=1 on first access cycle each time; prdata=0xA5A5_1234; pslverr=0.
REQ-033 The bench SHALL cover this case: WAIT_CYC=3, read -> pready low for 3 access cycles, high on 4th; prdata=0 until then.
REQ-034 The bench SHALL cover this case: word 0x04 holds 0x1111_1111, write 0xFFFF_FFFF with pstrb=0x5 -> readback 0x11FF_11FF.
REQ-035 The bench SHALL cover this case: DEPTH=32, read paddr 0x80 -> pready=1, pslverr=1, prdata=0; memory unchanged.
REQ-036 The bench SHALL cover this case: prstn pulled low during WAIT of a write to 0x10 -> pready=0 immediately; word 0x10 retains old value.
REQ-037 The bench SHALL cover this case: psel dropped after SETUP of a write, then penable=1 with no setup -> no write; pready stays 0; FSM IDLE.
